// File: rtl/plot_scheduler.sv
// Round-robin arbiter sharing one VGA pixel-write path between ball, paddle and block plotters.
// The winner's old rectangle is erased in the background colour, then its new one is drawn, one pixel per clock.
module plot_scheduler #(
  parameter logic [7:0] MAX_X     = 8'd159,
  parameter logic [6:0] MAX_Y     = 7'd119,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [2:0] COLOUR_0  = 3'b111,
  parameter logic [2:0] COLOUR_1  = 3'b010,
  parameter logic [2:0] COLOUR_2  = 3'b100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [23:0] new_x,
  input  logic [20:0] new_y,
  input  logic [23:0] old_x,
  input  logic [20:0] old_y,
  input  logic [23:0] size_x,
  input  logic [20:0] size_y,
  output logic [2:0]  ack,
  output logic        busy,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ERASE = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_grant;
  logic [7:0] r_px;
  logic [6:0] r_py;
  logic [7:0] r_oldX, r_newX, r_sizeX;
  logic [6:0] r_oldY, r_newY, r_sizeY;
  logic [2:0] r_ack;
  logic       r_busy;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;

  logic       w_grantValid;
  logic [1:0] w_grantIdx;
  logic [2:0] w_cand;
  logic [7:0] w_selOldX, w_selNewX, w_selSizeX;
  logic [6:0] w_selOldY, w_selNewY, w_selSizeY;
  logic       w_skipErase;
  logic [2:0] w_drawColour;
  logic [7:0] w_baseX;
  logic [6:0] w_baseY;
  logic [8:0] w_sumX;
  logic [7:0] w_sumY;
  logic       w_visible;
  logic       w_lastX;
  logic       w_lastY;
  logic       w_empty;

  // Lowest rotation offset from the pointer wins, so scan offsets from high to low.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = 2'd0;
    w_cand       = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      w_cand = {1'b0, r_ptr} + 3'(k);
      if (w_cand >= 3'd3) w_cand = w_cand - 3'd3;
      if (req[w_cand[1:0]]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = w_cand[1:0];
      end
    end
  end

  always_comb begin
    case (w_grantIdx)
      2'd1: begin
        w_selOldX = old_x[15:8];  w_selNewX = new_x[15:8];  w_selSizeX = size_x[15:8];
        w_selOldY = old_y[13:7];  w_selNewY = new_y[13:7];  w_selSizeY = size_y[13:7];
      end
      2'd2: begin
        w_selOldX = old_x[23:16]; w_selNewX = new_x[23:16]; w_selSizeX = size_x[23:16];
        w_selOldY = old_y[20:14]; w_selNewY = new_y[20:14]; w_selSizeY = size_y[20:14];
      end
      default: begin
        w_selOldX = old_x[7:0];   w_selNewX = new_x[7:0];   w_selSizeX = size_x[7:0];
        w_selOldY = old_y[6:0];   w_selNewY = new_y[6:0];   w_selSizeY = size_y[6:0];
      end
    endcase
  end

  assign w_skipErase = (w_selSizeX == 8'd0) || (w_selSizeY == 7'd0) ||
                       ((w_selOldX == w_selNewX) && (w_selOldY == w_selNewY));

  always_comb begin
    case (r_grant)
      2'd1:    w_drawColour = COLOUR_1;
      2'd2:    w_drawColour = COLOUR_2;
      default: w_drawColour = COLOUR_0;
    endcase
  end

  // Sums are one bit wider than the screen coordinates so that wrap past 255/127 still reads as off-screen.
  assign w_baseX   = (r_state == S_ERASE) ? r_oldX : r_newX;
  assign w_baseY   = (r_state == S_ERASE) ? r_oldY : r_newY;
  assign w_sumX    = {1'b0, w_baseX} + {1'b0, r_px};
  assign w_sumY    = {1'b0, w_baseY} + {1'b0, r_py};
  assign w_visible = (w_sumX <= {1'b0, MAX_X}) && (w_sumY <= {1'b0, MAX_Y});
  assign w_lastX   = (r_px == r_sizeX - 8'd1);
  assign w_lastY   = (r_py == r_sizeY - 7'd1);
  assign w_empty   = (r_sizeX == 8'd0) || (r_sizeY == 7'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_ptr    <= 2'd0;
      r_grant  <= 2'd0;
      r_px     <= 8'd0;
      r_py     <= 7'd0;
      r_oldX   <= 8'd0;
      r_newX   <= 8'd0;
      r_sizeX  <= 8'd0;
      r_oldY   <= 7'd0;
      r_newY   <= 7'd0;
      r_sizeY  <= 7'd0;
      r_ack    <= 3'b000;
      r_busy   <= 1'b0;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'b000;
      r_plot   <= 1'b0;
    end else begin
      r_ack  <= 3'b000;
      r_plot <= 1'b0;
      r_busy <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_grantValid) begin
            r_grant <= w_grantIdx;
            r_oldX  <= w_selOldX;
            r_newX  <= w_selNewX;
            r_sizeX <= w_selSizeX;
            r_oldY  <= w_selOldY;
            r_newY  <= w_selNewY;
            r_sizeY <= w_selSizeY;
            r_px    <= 8'd0;
            r_py    <= 7'd0;
            r_state <= w_skipErase ? S_DRAW : S_ERASE;
          end
        end
        S_ERASE, S_DRAW: begin
          if ((r_state == S_DRAW) && w_empty) begin
            r_state <= S_DONE;
          end else begin
            r_x      <= w_sumX[7:0];
            r_y      <= w_sumY[6:0];
            r_colour <= (r_state == S_ERASE) ? BG_COLOUR : w_drawColour;
            r_plot   <= w_visible;
            if (w_lastX) begin
              r_px <= 8'd0;
              if (w_lastY) begin
                r_py    <= 7'd0;
                r_state <= (r_state == S_ERASE) ? S_DRAW : S_DONE;
              end else begin
                r_py <= r_py + 7'd1;
              end
            end else begin
              r_px <= r_px + 8'd1;
            end
          end
        end
        S_DONE: begin
          r_ack   <= 3'b001 << r_grant;
          r_ptr   <= (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack    = r_ack;
  assign busy   = r_busy;
  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;

endmodule

// File: tb/tb_plot_scheduler.sv
// Scoreboard bench for plot_scheduler: directed requests push expected pixels/acks,
// a negedge monitor pops and compares whenever plot or ack is presented.
module tb_plot_scheduler;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [23:0] newX = '0, oldX = '0, sizeX = '0;
  logic [20:0] newY = '0, oldY = '0, sizeY = '0;
  logic [2:0]  ack;
  logic        busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  plot_scheduler dut (
    .clk(clk), .resetn(resetn), .req(req),
    .new_x(newX), .new_y(newY), .old_x(oldX), .old_y(oldY),
    .size_x(sizeX), .size_y(sizeY),
    .ack(ack), .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         isAck;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic [2:0] ack;
  } expEvent_t;

  expEvent_t expQ[$];
  expEvent_t monEvent;
  int nChecks = 0;
  int nFails = 0;
  int plotCount = 0;
  logic [2:0] prevAck = 3'b000;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    nChecks++;
    if (actual !== required) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Monitor: every presented pixel or ack must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!resetn) begin
      prevAck = 3'b000;
    end else begin
      if (plot) plotCount++;
      if (ack != 3'b000) begin
        checkOutput("ackOneHot", $countones(ack), 1);
        checkOutput("ackPulseWidth", prevAck, 3'b000);
      end
      if (plot || ack != 3'b000) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpectedOutput: got plot=%0b ack=%b x=%0d y=%0d colour=%b, expected nothing",
                   plot, ack, x, y, colour);
        end else begin
          monEvent = expQ.pop_front();
          if (monEvent.isAck)
            checkOutput("ackEvent", {28'd0, plot, ack}, {29'd0, monEvent.ack});
          else
            checkOutput("pixel", {11'd0, ack, x, y, colour},
                        {14'd0, monEvent.x, monEvent.y, monEvent.colour});
        end
      end
      prevAck = ack;
    end
  end

  task automatic pushRect(input int ox, input int oy, input int sx, input int sy, input logic [2:0] col);
    expEvent_t e;
    for (int py = 0; py < sy; py++) begin
      for (int px = 0; px < sx; px++) begin
        if ((ox + px) <= 159 && (oy + py) <= 119) begin
          e.isAck  = 1'b0;
          e.x      = 8'(ox + px);
          e.y      = 7'(oy + py);
          e.colour = col;
          e.ack    = 3'b000;
          expQ.push_back(e);
        end
      end
    end
  endtask

  task automatic pushAck(input logic [2:0] a);
    expEvent_t e;
    e.isAck  = 1'b1;
    e.x      = 8'd0;
    e.y      = 7'd0;
    e.colour = 3'b000;
    e.ack    = a;
    expQ.push_back(e);
  endtask

  task automatic setGeom(input int idx, input int ox, input int oy, input int nx, input int ny,
                         input int sx, input int sy);
    oldX[idx*8 +: 8]  = 8'(ox);
    newX[idx*8 +: 8]  = 8'(nx);
    sizeX[idx*8 +: 8] = 8'(sx);
    oldY[idx*7 +: 7]  = 7'(oy);
    newY[idx*7 +: 7]  = 7'(ny);
    sizeY[idx*7 +: 7] = 7'(sy);
  endtask

  // Counts posedges from the one that samples req (counted as 1) until ack is visible.
  task automatic waitAck(output int edges);
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (ack != 3'b000) break;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input int expectedEdges, input string name);
    int edges;
    @(posedge clk);
    #1;
    req = r;
    waitAck(edges);
    req = 3'b000;
    checkOutput({name, "Latency"}, edges, expectedEdges);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, "Drained"}, expQ.size(), 0);
    checkOutput({name, "IdleBusy"}, busy, 1'b0);
  endtask

  initial begin
    int edges;
    logic [2:0] rrOrder[4];
    rrOrder[0] = 3'b001; rrOrder[1] = 3'b010; rrOrder[2] = 3'b100; rrOrder[3] = 3'b001;

    #1 resetn = 1'b0;
    #11;
    checkOutput("resetAck", ack, 3'b000);
    checkOutput("resetBusy", busy, 1'b0);
    checkOutput("resetPlot", plot, 1'b0);
    checkOutput("resetX", x, 8'd0);
    checkOutput("resetY", y, 7'd0);
    checkOutput("resetColour", colour, 3'b000);
    @(negedge clk) resetn = 1'b1;

    // Ball 4x4 moving (10,20) -> (11,21): 16 erase + 16 draw pixels.
    setGeom(0, 10, 20, 11, 21, 4, 4);
    pushRect(10, 20, 4, 4, 3'b000);
    pushRect(11, 21, 4, 4, 3'b111);
    pushAck(3'b001);
    applyStimulus(3'b001, 34, "ball");

    // Paddle 20x1 unmoved: no erase, 20 draw pixels.
    setGeom(1, 100, 115, 100, 115, 20, 1);
    pushRect(100, 115, 20, 1, 3'b010);
    pushAck(3'b010);
    applyStimulus(3'b010, 22, "paddle");

    // Block 8x4 at the bottom-right corner: only 4x3 of the scan is visible.
    setGeom(2, 156, 117, 156, 117, 8, 4);
    pushRect(156, 117, 8, 4, 3'b100);
    pushAck(3'b100);
    plotCount = 0;
    applyStimulus(3'b100, 34, "block");
    checkOutput("blockPlotCount", plotCount, 12);

    // Zero-width request: no pixels, ack two edges after the grant edge.
    setGeom(0, 10, 20, 30, 40, 0, 4);
    pushAck(3'b001);
    plotCount = 0;
    applyStimulus(3'b001, 3, "zeroWidth");
    checkOutput("zeroWidthPlotCount", plotCount, 0);

    // All three requesting from reset: served 0,1,2,0 with one idle cycle between.
    resetn = 1'b0;
    req = 3'b111;
    setGeom(0, 0, 0, 1, 1, 1, 1);
    setGeom(1, 2, 2, 3, 3, 1, 1);
    setGeom(2, 4, 4, 5, 5, 1, 1);
    pushRect(0, 0, 1, 1, 3'b000); pushRect(1, 1, 1, 1, 3'b111); pushAck(3'b001);
    pushRect(2, 2, 1, 1, 3'b000); pushRect(3, 3, 1, 1, 3'b010); pushAck(3'b010);
    pushRect(4, 4, 1, 1, 3'b000); pushRect(5, 5, 1, 1, 3'b100); pushAck(3'b100);
    pushRect(0, 0, 1, 1, 3'b000); pushRect(1, 1, 1, 1, 3'b111); pushAck(3'b001);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitAck(edges);
      checkOutput("rrOrder", ack, rrOrder[i]);
      checkOutput("rrBusyDuringAck", busy, 1'b1);
      if (i == 3) begin
        req = 3'b000;
      end else begin
        @(posedge clk); #1;
        checkOutput("rrBusyGap", busy, 1'b0);
        @(posedge clk); #1;
        checkOutput("rrBusyResume", busy, 1'b1);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rrDrained", expQ.size(), 0);

    // Reset in the middle of a draw: outputs clear at once and no ack follows.
    setGeom(0, 10, 20, 11, 21, 4, 4);
    pushRect(10, 20, 4, 4, 3'b000);
    pushRect(11, 21, 4, 4, 3'b111);
    pushAck(3'b001);
    @(posedge clk);
    #1 req = 3'b001;
    repeat (22) @(posedge clk);
    #2;
    req = 3'b000;
    resetn = 1'b0;
    #1;
    checkOutput("midResetPlot", plot, 1'b0);
    checkOutput("midResetBusy", busy, 1'b0);
    expQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("midResetNoAck", ack, 3'b000);
    end
    checkOutput("midResetIdle", busy, 1'b0);

    setGeom(1, 100, 115, 100, 115, 20, 1);
    pushRect(100, 115, 20, 1, 3'b010);
    pushAck(3'b010);
    applyStimulus(3'b010, 22, "afterReset");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/plot_scheduler.md
Name: plot_scheduler

Overview:
- Shares the single pixel-write path into the VGA adapter between three rectangle-plotting requesters: ball (0), paddle (1), block (2).
- Each requester presents an old and a new rectangle. The scheduler arbitrates round-robin and latches the winner's geometry.
- It then erases the old rectangle with the background colour and draws the new one with that requester's colour, one pixel per clock.
- Sits between game logic and vga_adapter; replaces the direct startPlot/object hand-off.

Parameters:
- MAX_X, 159, rightmost visible column; pixels with x > MAX_X are suppressed.
- MAX_Y, 119, bottom visible row; pixels with y > MAX_Y are suppressed.
- BG_COLOUR, 3'b000, colour used during the erase phase.
- COLOUR_0, 3'b111, draw colour for requester 0 (ball).
- COLOUR_1, 3'b010, draw colour for requester 1 (paddle).
- COLOUR_2, 3'b100, draw colour for requester 2 (block).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req  in  3  per-requester plot request; level, held until matching ack
- new_x  in  24  three 8-bit new X origins; requester i occupies bits [8i+7:8i]
- new_y  in  21  three 7-bit new Y origins, packed 7 bits per requester
- old_x  in  24  three 8-bit old X origins
- old_y  in  21  three 7-bit old Y origins
- size_x  in  24  three 8-bit widths
- size_y  in  21  three 7-bit heights
- ack  out  3  one-cycle pulse, one-hot, when the granted request completes
- busy  out  1  high in any state other than IDLE
- x  out  8  pixel X to vga_adapter
- y  out  7  pixel Y to vga_adapter
- colour  out  3  pixel colour to vga_adapter
- plot  out  1  vga_adapter write enable

Behaviour:
- Reset (async, resetn=0): state=IDLE; ack=0, busy=0, plot=0, x=0, y=0, colour=0; round-robin pointer=0; all counters 0.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE
  - If req != 0, grant the first requester with req set, searching from the pointer upward with wrap-around (pointer, pointer+1, pointer+2, mod 3).
  - On grant, latch that requester's six fields, clear px/py counters and go to ERASE.
  - Go straight to DRAW instead if size_x==0, size_y==0, or (old_x==new_x and old_y==new_y).
- ERASE
  - Each cycle: x=old_x+px, y=old_y+py, colour=BG_COLOUR.
  - plot=1 unless x>MAX_X or y>MAX_Y; the sum is computed at 9/8 bits so wrap is detected.
  - px increments; at px==size_x-1, px=0 and py increments.
  - At the last pixel (px==size_x-1, py==size_y-1), clear counters and go to DRAW.
- DRAW
  - Same scan over new_x/new_y with the granted requester's colour; after the last pixel go to DONE.
  - If size_x==0 or size_y==0, DRAW lasts 0 pixels: next state is DONE with plot=0.
- DONE
  - Single cycle: plot=0, ack[grant]=1.
  - Pointer = (grant+1) mod 3. Return to IDLE.
- Outputs x/y/colour/plot are registered; the first erase pixel appears the cycle after grant.
- Latched geometry is immune to input changes after grant.
- Requests arriving while busy are held and serviced in round-robin order.
- A request deasserted before grant is simply not served. Deassertion after grant does not abort the operation.
- Total cycles grant→ack = 1 + eraseCount + drawCount + 1.
- Reset mid-operation returns to IDLE immediately; no ack is issued and partial pixels are left on screen.

Test Plan:
- Ball 4x4, old (10,20), new (11,21), req=001 → 16 erase pixels colour 000 from (10,20) to (13,23), then 16 draw pixels colour 111 from (11,21) to (14,24); ack=001 exactly 34 cycles after the req edge is sampled.
- Paddle 20x1, old=new=(100,115) → erase skipped; 20 pixels colour 010 at y=115, x=100..119; ack=010.
- req=111 held continuously from reset → service order ball, paddle, block, ball; each ack one-hot and one cycle wide; busy drops for exactly one IDLE cycle between services.
- Block 8x4 at new (156,117) → only x 156..159 with y 117..119 have plot=1 (12 pixels); the other 20 scan cycles have plot=0; ack still issued.
- size_x=0 request → no plot pulses; ack 2 cycles after grant.
- resetn pulsed low mid-DRAW → plot=0 and busy=0 asynchronously; no ack; after release, a fresh req=010 is granted normally.
